led_status_driver: RTL and testbench



---
 rtl/led_status_driver.sv | 163 ++++++++++++++++
 tb/tb_led_status_driver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_status_driver.sv
`default_nettype none
// ============================================================================
// Module  : led_status_driver
// Purpose : Multi-channel status-LED driver with OFF/ON/BLINK/ACTIVITY modes
//           and per-channel PWM brightness. Optional macro LED_EVENT_SYNC_EN
//           adds a 2-flop synchroniser and rising-edge detector per event bit.
// Revision: 1.0 - initial release
// ============================================================================
module led_status_driver #(
  parameter int NCH      = 4,
  parameter int DIV_BITS = 27,
  parameter int STRETCH  = 24,
  parameter int PWM_BITS = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [2*NCH-1:0]          mode,
  input  logic [NCH-1:0]            evt,
  input  logic [PWM_BITS*NCH-1:0]   bright,
  output logic [NCH-1:0]            led
);

  localparam logic [1:0] c_MODE_OFF   = 2'b00;
  localparam logic [1:0] c_MODE_ON    = 2'b01;
  localparam logic [1:0] c_MODE_BLINK = 2'b10;
  localparam logic [1:0] c_MODE_ACT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LIT  = 2'b01,
    ST_DARK = 2'b10
  } act_state_t;

  logic [DIV_BITS-1:0] r_div_cnt;
  logic                w_blink_ph;
  logic [PWM_BITS-1:0] w_pwm_cnt;
  logic [NCH-1:0]      w_evt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_div_cnt <= '0;
    else         r_div_cnt <= r_div_cnt + 1'b1;
  end

  assign w_blink_ph = r_div_cnt[DIV_BITS-1];
  assign w_pwm_cnt  = r_div_cnt[PWM_BITS-1:0];

`ifdef LED_EVENT_SYNC_EN
  // Each input 0->1 transition becomes a single-cycle event strobe.
  logic [NCH-1:0] r_sync1, r_sync2, r_prev, r_rise;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_rise  <= '0;
    end else begin
      r_sync1 <= evt;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_rise  <= r_sync2 & ~r_prev;
    end
  end

  assign w_evt = r_rise;
`else
  assign w_evt = evt;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    act_state_t          r_state;
    logic [STRETCH-1:0]  r_cnt;
    logic                r_pend;
    logic                r_led;
    logic [1:0]          w_mode;
    logic [PWM_BITS-1:0] w_bright;
    logic                w_pwm_on;
    logic                w_raw;
    logic                w_cnt_max;

    assign w_mode    = mode[2*i +: 2];
    assign w_bright  = bright[PWM_BITS*i +: PWM_BITS];
    assign w_cnt_max = &r_cnt;

    // Full-scale brightness is forced on; the plain compare would drop one slot.
    always_comb begin
      w_pwm_on = 1'b0;
      if (w_bright == '0)  w_pwm_on = 1'b0;
      else if (&w_bright)  w_pwm_on = 1'b1;
      else                 w_pwm_on = (w_pwm_cnt < w_bright);
    end

    always_comb begin
      w_raw = 1'b0;
      case (w_mode)
        c_MODE_OFF:   w_raw = 1'b0;
        c_MODE_ON:    w_raw = 1'b1;
        c_MODE_BLINK: w_raw = w_blink_ph;
        c_MODE_ACT:   w_raw = (r_state == ST_LIT);
        default:      w_raw = 1'b0;
      endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_pend  <= 1'b0;
        r_led   <= 1'b0;
      end else begin
        r_led <= w_raw & w_pwm_on;
        if (w_mode != c_MODE_ACT) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_pend  <= 1'b0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_evt[i] || r_pend) begin
                r_state <= ST_LIT;
                r_cnt   <= '0;
                r_pend  <= 1'b0;
              end
            end
            ST_LIT: begin
              r_cnt <= r_cnt + 1'b1;
              if (w_evt[i]) r_pend <= 1'b1;
              if (w_cnt_max) begin
                r_state <= ST_DARK;
                r_cnt   <= '0;
              end
            end
            ST_DARK: begin
              r_cnt <= r_cnt + 1'b1;
              if (w_cnt_max) begin
                r_cnt <= '0;
                if (r_pend) begin
                  r_state <= ST_LIT;
                  r_pend  <= 1'b0;
                end else begin
                  // An event on the final dark cycle is kept for the next cycle.
                  r_state <= ST_IDLE;
                  r_pend  <= w_evt[i];
                end
              end else if (w_evt[i]) begin
                r_pend <= 1'b1;
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_pend  <= 1'b0;
            end
          endcase
        end
      end
    end

    assign led[i] = r_led;
  end

endmodule
`default_nettype wire

// File: tb/tb_led_status_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_status_driver
// Purpose : Directed self-checking bench for led_status_driver
//           (NCH=4, DIV_BITS=6, STRETCH=3, PWM_BITS=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_status_driver;

  logic       clk;
  logic       resetn;
  logic [7:0] mode;
  logic [3:0] evt;
  logic [7:0] bright;
  logic [3:0] led;

  int n_cmp;
  int n_err;

  led_status_driver #(
    .NCH      (4),
    .DIV_BITS (6),
    .STRETCH  (3),
    .PWM_BITS (2)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .mode   (mode),
    .evt    (evt),
    .bright (bright),
    .led    (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves time at edge+3 with reset released; the next tick is edge n=1.
  task automatic apply_reset(input logic [7:0] m, input logic [3:0] e, input logic [7:0] b);
    resetn = 1'b0;
    mode   = m;
    evt    = e;
    bright = b;
    @(posedge clk);
    #1;
    n_cmp++;
    if (led !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_hold: led=%b expected %b", led, 4'b0000);
    end
    #2;
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    logic [3:0] exp;
    // ch1 blinks so the prescaler restart is visible; others ON at full brightness
    apply_reset(8'b01011001, 4'b0000, 8'hFF);
    for (int n = 1; n <= 40; n++) begin
      tick;
      exp = (n >= 33) ? 4'b1111 : 4'b1101;
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL reset_run n=%0d: led=%b expected %b", n, led, exp);
      end
    end
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (led !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_async: led=%b expected %b", led, 4'b0000);
    end
    #2;
    resetn = 1'b1;
    for (int n = 1; n <= 34; n++) begin
      tick;
      exp = (n >= 33) ? 4'b1111 : 4'b1101;
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL reset_restart n=%0d: led=%b expected %b", n, led, exp);
      end
    end
  endtask

  task automatic test_pwm;
    logic [1:0] levels [4];
    logic [3:0] exp;
    levels[0] = 2'd3;
    levels[1] = 2'd1;
    levels[2] = 2'd2;
    levels[3] = 2'd0;
    for (int b = 0; b < 4; b++) begin
      apply_reset(8'b00000001, 4'b0000, {6'b000000, levels[b]});
      for (int n = 1; n <= 8; n++) begin
        tick;
        case (levels[b])
          2'd3:    exp = 4'b0001;
          2'd1:    exp = ((n % 4) == 1) ? 4'b0001 : 4'b0000;
          2'd2:    exp = (((n - 1) % 4) < 2) ? 4'b0001 : 4'b0000;
          default: exp = 4'b0000;
        endcase
        n_cmp++;
        if (led !== exp) begin
          n_err++;
          $display("FAIL pwm b=%0d n=%0d: led=%b expected %b", levels[b], n, led, exp);
        end
      end
    end
  endtask

  task automatic test_blink;
    logic [3:0] exp;
    apply_reset(8'b00001000, 4'b0000, 8'b00001100);
    for (int n = 1; n <= 66; n++) begin
      tick;
      exp = (((n - 1) % 64) >= 32) ? 4'b0010 : 4'b0000;
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL blink_full n=%0d: led=%b expected %b", n, led, exp);
      end
    end
    apply_reset(8'b00001000, 4'b0000, 8'b00001000);
    for (int n = 1; n <= 64; n++) begin
      tick;
      exp = ((n >= 33) && (((n - 1) % 4) < 2)) ? 4'b0010 : 4'b0000;
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL blink_dim n=%0d: led=%b expected %b", n, led, exp);
      end
    end
  endtask

`ifndef LED_EVENT_SYNC_EN
  task automatic test_activity_single;
    logic [3:0] exp;
    apply_reset(8'b00110000, 4'b0000, 8'b00110000);
    tick;
    tick;
    evt = 4'b0100;
    tick;
    evt = 4'b0000;
    n_cmp++;
    if (led !== 4'b0000) begin
      n_err++;
      $display("FAIL act_edge_k: led=%b expected %b", led, 4'b0000);
    end
    // second event lands exactly on the final dark cycle
    for (int j = 1; j <= 33; j++) begin
      if (j == 16) evt = 4'b0100;
      tick;
      evt = 4'b0000;
      exp = (((j >= 1) && (j <= 8)) || ((j >= 18) && (j <= 25))) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL act_boundary j=%0d: led=%b expected %b", j, led, exp);
      end
    end
    evt = 4'b0100;
    tick;
    evt = 4'b0000;
    for (int j = 1; j <= 40; j++) begin
      if (j == 11) evt = 4'b0100;
      tick;
      evt = 4'b0000;
      exp = (((j >= 1) && (j <= 8)) || ((j >= 17) && (j <= 24))) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL act_pending j=%0d: led=%b expected %b", j, led, exp);
      end
    end
  endtask

  task automatic test_activity_continuous;
    logic [3:0] exp;
    apply_reset(8'b11000000, 4'b1000, 8'b11000000);
    for (int n = 1; n <= 40; n++) begin
      tick;
      exp = ((n >= 2) && (((n - 2) % 16) < 8)) ? 4'b1000 : 4'b0000;
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL act_cont n=%0d: led=%b expected %b", n, led, exp);
      end
    end
    mode = 8'b00000000;
    evt  = 4'b0000;
    tick;
    n_cmp++;
    if (led !== 4'b0000) begin
      n_err++;
      $display("FAIL act_abort: led=%b expected %b", led, 4'b0000);
    end
    tick;
    tick;
    mode = 8'b11000000;
    for (int n = 1; n <= 20; n++) begin
      tick;
      n_cmp++;
      if (led !== 4'b0000) begin
        n_err++;
        $display("FAIL act_reenter n=%0d: led=%b expected %b", n, led, 4'b0000);
      end
    end
  endtask
`else
  task automatic test_event_sync;
    logic [3:0] exp;
    apply_reset(8'b00110000, 4'b0000, 8'b00110000);
    tick;
    evt = 4'b0100;
    for (int j = 0; j <= 105; j++) begin
      if (j == 100) evt = 4'b0000;
      tick;
      exp = ((j >= 4) && (j <= 11)) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (led !== exp) begin
        n_err++;
        $display("FAIL sync_level j=%0d: led=%b expected %b", j, led, exp);
      end
    end
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    resetn = 1'b0;
    mode   = 8'h00;
    evt    = 4'h0;
    bright = 8'h00;
    test_reset;
    test_pwm;
    test_blink;
`ifndef LED_EVENT_SYNC_EN
    test_activity_single;
    test_activity_continuous;
`else
    test_event_sync;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
